// File: rtl/cc_frogger_pkg.sv
// cc_frogger_pkg: shared state encoding and default lives/respawn settings
package cc_frogger_pkg;
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PLAY     = 2'd1,
    S_DYING    = 2'd2,
    S_GAMEOVER = 2'd3
  } state_t;
  localparam int DEF_INITIAL_LIVES = 3;
  localparam int DEF_MAX_LIVES     = 7;
  localparam int DEF_RESPAWN_DELAY = 4;
endpackage

// File: rtl/cc_lives_counter.sv
// cc_lives_counter: lives register with load, floor-at-zero decrement and saturating increment
// Ports: clk/rst (sync, active-high, reloads INIT), load/dec/inc controls (load wins, then dec), lives count out.
module cc_lives_counter #(
  parameter int W    = 3,
  parameter int INIT = 3,
  parameter int MAX  = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] lives
);
  always_ff @(posedge clk) begin
    if (rst || load) lives <= W'(INIT);
    else if (dec) lives <= (lives == '0) ? lives : lives - W'(1);
    else if (inc) lives <= (lives >= W'(MAX)) ? W'(MAX) : lives + W'(1);
  end
endmodule

// File: rtl/cc_lives_controller.sv
// cc_lives_controller: frogger lives FSM (IDLE/PLAY/DYING/GAMEOVER) with registered flags and respawn delay
// Ports: CLOCK_50 clock, RESET_InHigh sync active-high reset, start/hit/goal inputs,
//   lives_Out count, playing/respawn/gameover flags (all registered).
// Optional feature: define CC_LIVES_BONUS_EN to make goal add a saturating bonus life.
module cc_lives_controller
  import cc_frogger_pkg::*;
#(
  parameter int LIVES_COUNTER_DATAWIDTH = 3,
  parameter int INITIAL_LIVES           = DEF_INITIAL_LIVES,
  parameter int MAX_LIVES               = DEF_MAX_LIVES,
  parameter int RESPAWN_DELAY           = DEF_RESPAWN_DELAY
) (
  input  logic                               CC_LIVES_CONTROLLER_CLOCK_50,
  input  logic                               CC_LIVES_CONTROLLER_RESET_InHigh,
  input  logic                               CC_LIVES_CONTROLLER_start_InHigh,
  input  logic                               CC_LIVES_CONTROLLER_hit_InHigh,
  input  logic                               CC_LIVES_CONTROLLER_goal_InHigh,
  output logic [LIVES_COUNTER_DATAWIDTH-1:0] CC_LIVES_CONTROLLER_lives_Out,
  output logic                               CC_LIVES_CONTROLLER_playing_OutHigh,
  output logic                               CC_LIVES_CONTROLLER_respawn_OutHigh,
  output logic                               CC_LIVES_CONTROLLER_gameover_OutHigh
);
  localparam int W = LIVES_COUNTER_DATAWIDTH;
`ifdef CC_LIVES_BONUS_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif
  logic clk, rst, start, hit, goal;
  assign clk   = CC_LIVES_CONTROLLER_CLOCK_50;
  assign rst   = CC_LIVES_CONTROLLER_RESET_InHigh;
  assign start = CC_LIVES_CONTROLLER_start_InHigh;
  assign hit   = CC_LIVES_CONTROLLER_hit_InHigh;
  assign goal  = CC_LIVES_CONTROLLER_goal_InHigh;
  state_t state, nxt;
  logic [7:0] dly, dly_nxt;
  logic load, dec, inc, rsp_nxt;
  logic [W-1:0] lives;
  always_ff @(posedge clk) begin
    if (rst) begin
      state                                <= S_IDLE;
      dly                                  <= '0;
      CC_LIVES_CONTROLLER_playing_OutHigh  <= 1'b0;
      CC_LIVES_CONTROLLER_respawn_OutHigh  <= 1'b0;
      CC_LIVES_CONTROLLER_gameover_OutHigh <= 1'b0;
    end else begin
      state                                <= nxt;
      dly                                  <= dly_nxt;
      CC_LIVES_CONTROLLER_playing_OutHigh  <= nxt == S_PLAY;
      CC_LIVES_CONTROLLER_respawn_OutHigh  <= rsp_nxt;
      CC_LIVES_CONTROLLER_gameover_OutHigh <= nxt == S_GAMEOVER;
    end
  end
  // Hit beats goal; a hit on the last life skips DYING and ends the game.
  always_comb begin
    nxt     = state;
    dly_nxt = dly;
    load    = 1'b0;
    dec     = 1'b0;
    inc     = 1'b0;
    rsp_nxt = 1'b0;
    case (state)
      S_IDLE, S_GAMEOVER: begin
        load    = start;
        rsp_nxt = start;
        nxt     = start ? S_PLAY : state;
      end
      S_PLAY: begin
        dec     = hit && lives != '0;
        inc     = BONUS && goal && !hit;
        nxt     = !hit ? S_PLAY : lives > W'(1) ? S_DYING : lives == W'(1) ? S_GAMEOVER : S_PLAY;
        dly_nxt = (hit && lives > W'(1)) ? 8'(RESPAWN_DELAY) : dly;
      end
      default: begin
        dly_nxt = (dly == '0) ? dly : dly - 8'd1;
        rsp_nxt = dly <= 8'd1;
        nxt     = (dly <= 8'd1) ? S_PLAY : S_DYING;
      end
    endcase
  end
  cc_lives_counter #(.W(W), .INIT(INITIAL_LIVES), .MAX(MAX_LIVES)) u_cnt (
    .clk(clk), .rst(rst), .load(load), .dec(dec), .inc(inc), .lives(lives)
  );
  assign CC_LIVES_CONTROLLER_lives_Out = lives;
endmodule

// File: tb/tb_cc_lives_controller.sv
// tb_cc_lives_controller: table-driven and directed checks of the lives controller
module tb_cc_lives_controller;
`ifdef CC_LIVES_BONUS_EN
  localparam bit BON = 1'b1;
`else
  localparam bit BON = 1'b0;
`endif
  typedef struct {
    logic r, s, h, g;
    int   l;
    logic p, rs, go;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, hit = 1'b0, goal = 1'b0;
  logic [2:0] lives;
  logic playing, respawn, gameover;
  int tests = 0, fails = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  cc_lives_controller dut (
    .CC_LIVES_CONTROLLER_CLOCK_50(clk),
    .CC_LIVES_CONTROLLER_RESET_InHigh(rst),
    .CC_LIVES_CONTROLLER_start_InHigh(start),
    .CC_LIVES_CONTROLLER_hit_InHigh(hit),
    .CC_LIVES_CONTROLLER_goal_InHigh(goal),
    .CC_LIVES_CONTROLLER_lives_Out(lives),
    .CC_LIVES_CONTROLLER_playing_OutHigh(playing),
    .CC_LIVES_CONTROLLER_respawn_OutHigh(respawn),
    .CC_LIVES_CONTROLLER_gameover_OutHigh(gameover)
  );
  task automatic add(input logic r, s, h, g, input int l, input logic p, rs, go);
    vec_t v;
    v.r = r; v.s = s; v.h = h; v.g = g; v.l = l; v.p = p; v.rs = rs; v.go = go;
    tbl.push_back(v);
  endtask
  task automatic step(input logic r, s, h, g);
    @(negedge clk);
    rst = r; start = s; hit = h; goal = g;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input int l, input logic p, rs, go);
    tests++;
    if (int'(lives) != l || playing !== p || respawn !== rs || gameover !== go) begin
      fails++;
      $display("FAIL %s: got lives=%0d play=%b resp=%b gover=%b, want lives=%0d play=%b resp=%b gover=%b",
               name, lives, playing, respawn, gameover, l, p, rs, go);
    end
  endtask
  task automatic wait_respawn(input string name);
    int n;
    n = 0;
    while (respawn !== 1'b1 && n < 20) begin
      step(0, 0, 0, 0);
      n++;
    end
    tests++;
    if (n != 4) begin
      fails++;
      $display("FAIL %s: respawn after %0d cycles, want 4", name, n);
    end
  endtask
  initial begin
    add(1,0,0,0, 3,0,0,0);
    add(0,0,0,0, 3,0,0,0);
    add(0,0,1,0, 3,0,0,0);
    add(0,1,0,0, 3,1,1,0);
    add(0,0,0,0, 3,1,0,0);
    add(0,1,0,0, 3,1,0,0);
    add(0,0,1,0, 2,0,0,0);
    add(0,0,1,0, 2,0,0,0);
    add(0,1,0,0, 2,0,0,0);
    add(0,0,0,0, 2,0,0,0);
    add(0,0,0,0, 2,1,1,0);
    add(0,0,1,1, 1,0,0,0);
    add(0,0,0,1, 1,0,0,0);
    add(0,0,0,0, 1,0,0,0);
    add(0,0,0,0, 1,0,0,0);
    add(0,0,0,0, 1,1,1,0);
    add(0,0,1,0, 0,0,0,1);
    add(0,0,1,0, 0,0,0,1);
    add(0,0,0,1, 0,0,0,1);
    add(0,1,0,0, 3,1,1,0);
    for (int i = 1; i <= 5; i++) add(0,0,0,1, BON ? ((3 + i > 7) ? 7 : 3 + i) : 3, 1,0,0);
    add(0,0,1,0, BON ? 6 : 2, 0,0,0);
    add(0,0,0,0, BON ? 6 : 2, 0,0,0);
    add(1,0,0,0, 3,0,0,0);
    for (int i = 0; i < 4; i++) add(0,0,0,0, 3,0,0,0);
    add(0,1,0,0, 3,1,1,0);
    add(0,0,1,0, 2,0,0,0);
    add(1,1,0,0, 3,0,0,0);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].g);
      check($sformatf("vec%0d", i), tbl[i].l, tbl[i].p, tbl[i].rs, tbl[i].go);
    end
    step(0, 1, 0, 0);
    check("restart", 3, 1, 1, 0);
    step(0, 0, 1, 0);
    check("hit1", 2, 0, 0, 0);
    wait_respawn("delay1");
    step(0, 0, 0, 0);
    check("pulse_width", 2, 1, 0, 0);
    step(0, 0, 1, 0);
    check("hit2", 1, 0, 0, 0);
    wait_respawn("delay2");
    step(0, 0, 1, 0);
    check("hit3_gameover", 0, 0, 0, 1);
    step(1, 0, 0, 0);
    check("reset_gameover", 3, 0, 0, 0);
    step(0, 0, 0, 0);
    check("idle_after_reset", 3, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cc_lives_controller.md
CC_LIVES_CONTROLLER -- requirements
Module: cc_lives_controller

Interface
- REQ-001 SHALL have parameter LIVES_COUNTER_DATAWIDTH, default 3, width of the lives count.
- REQ-002 SHALL have parameter INITIAL_LIVES, default 3, lives loaded on game start.
- REQ-003 SHALL have parameter MAX_LIVES, default 7, bonus saturation ceiling; legal range INITIAL_LIVES <= MAX_LIVES <= 2^LIVES_COUNTER_DATAWIDTH-1.
- REQ-004 SHALL have parameter RESPAWN_DELAY, default 4, cycles spent in DYING; legal range 1..255.
- REQ-005 SHALL have port CC_LIVES_CONTROLLER_CLOCK_50, input, 1, single clock; all state updates on its rising edge.
- REQ-006 SHALL have port CC_LIVES_CONTROLLER_RESET_InHigh, input, 1, reset, synchronous, active-high.
- REQ-007 SHALL have port CC_LIVES_CONTROLLER_start_InHigh, input, 1, start/restart request, level-sampled.
- REQ-008 SHALL have port CC_LIVES_CONTROLLER_hit_InHigh, input, 1, frog collision, one-cycle pulse.
- REQ-009 SHALL have port CC_LIVES_CONTROLLER_goal_InHigh, input, 1, frog reached goal, one-cycle pulse.
- REQ-010 SHALL have port CC_LIVES_CONTROLLER_lives_Out, output, LIVES_COUNTER_DATAWIDTH, registered lives remaining.
- REQ-011 SHALL have port CC_LIVES_CONTROLLER_playing_OutHigh, output, 1, high only in state PLAY.
- REQ-012 SHALL have port CC_LIVES_CONTROLLER_respawn_OutHigh, output, 1, one-cycle pulse to reposition frog.
- REQ-013 SHALL have port CC_LIVES_CONTROLLER_gameover_OutHigh, output, 1, high only in state GAMEOVER.

Function
- REQ-014 SHALL implement states IDLE, PLAY, DYING, GAMEOVER; all outputs registered, responding one cycle after the input is sampled.
- REQ-015 IDLE: start=1 SHALL go to PLAY, load lives=INITIAL_LIVES, pulse respawn on the same edge.
- REQ-016 PLAY, hit=1, lives>1: SHALL decrement lives by 1, go to DYING, load delay counter with RESPAWN_DELAY.
- REQ-017 PLAY, hit=1, lives==1: SHALL set lives=0 and go to GAMEOVER; no respawn pulse.
- REQ-018 DYING: SHALL decrement delay counter each cycle; on the cycle counter==1, go to PLAY and pulse respawn; hit, goal, start ignored.
- REQ-019 GAMEOVER: SHALL hold lives=0; start=1 SHALL behave as REQ-015.
- REQ-020 start SHALL be ignored in PLAY and DYING.
- REQ-021 hit and goal in the same PLAY cycle: hit SHALL take priority; goal discarded.
- REQ-022 lives SHALL never underflow below 0 nor exceed MAX_LIVES; hit with lives==0 ignored.
- REQ-023 respawn SHALL be high for exactly one cycle per event.

Reset
- REQ-024 RESET_InHigh=1 at a clock edge SHALL force IDLE, lives=INITIAL_LIVES, delay counter=0, playing=0, respawn=0, gameover=0, overriding all other inputs.
- REQ-025 Reset mid-DYING or mid-GAMEOVER SHALL abort the state with no respawn pulse.

Configuration
- REQ-026 Macro CC_LIVES_BONUS_EN defined: goal=1 in PLAY (no simultaneous hit) SHALL increment lives by 1, saturating at MAX_LIVES.
- REQ-027 Macro CC_LIVES_BONUS_EN undefined: goal SHALL be ignored in every state; lives only decrease.

Structure
- REQ-028 State encodings (2-bit) and default INITIAL_LIVES/MAX_LIVES/RESPAWN_DELAY SHALL live in the shared package cc_frogger_pkg.
- REQ-029 The lives register with load/decrement/saturating-increment SHALL be sub-module cc_lives_counter; FSM and delay counter stay in the top.

Verification
- REQ-030 Reset, then start=1 one cycle -> lives=3, playing=1, respawn pulse of 1 cycle.
- REQ-031 In PLAY, hit pulse -> lives=2, playing=0 for 4 cycles, respawn pulse, playing=1.
- REQ-032 Three hits, each after respawn -> lives 2,1,0; third hit -> gameover=1, no respawn; then start -> lives=3, gameover=0.
- REQ-033 hit during DYING -> lives unchanged; hit+goal same cycle in PLAY -> lives decreases by 1 only.
- REQ-034 With CC_LIVES_BONUS_EN: 5 goal pulses from lives=3 -> lives 4,5,6,7,7; without: lives stays 3.
- REQ-035 Reset asserted in DYING cycle 2 -> next cycle IDLE, lives=3, all flags 0, no respawn pulse.
